spi_cfg_master: RTL

SPI_CFG_MASTER -- requirements
Module: spi_cfg_master

---
 rtl/psec5_spi_pkg.sv | 29 ++
 rtl/spi_cmd_fifo.sv | 73 +++++++
 rtl/spi_cfg_master.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/psec5_spi_pkg.sv
// -----------------------------------------------------------------------------
// psec5_spi_pkg
// Shared definitions for the SPI configuration master: FSM state encoding,
// frame geometry, the queued command record and the slave register map.
// -----------------------------------------------------------------------------
package psec5_spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        GAP
    } spi_state_t;

    localparam int FRAME_BITS = 16;

    // Slave register map
    localparam logic [7:0] ADDR_TRIG_MASK = 8'd1;
    localparam logic [7:0] ADDR_INSTR     = 8'd2;
    localparam logic [7:0] ADDR_MODE      = 8'd3;

    // One queued write; the packed layout puts addr in the low byte so that
    // shifting the whole record right sends address first, LSB first.
    typedef struct packed {
        logic [7:0] data;
        logic [7:0] addr;
    } spi_cmd_t;

endpackage

// File: rtl/spi_cmd_fifo.sv
// -----------------------------------------------------------------------------
// spi_cmd_fifo
// Synchronous command queue for the SPI configuration master.
//   iclk, rstn  : clock, asynchronous active-low reset
//   flush       : synchronous clear; any coincident push/pop is dropped
//   push, pop   : requests; push ignored when full, pop ignored when empty
//   wr_data     : command to enqueue
//   rd_data     : command at the head (valid while !empty)
//   full, empty : queue status
//   level       : number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module spi_cmd_fifo
    import psec5_spi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   iclk,
    input  logic                   rstn,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  spi_cmd_t               wr_data,
    output spi_cmd_t               rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    spi_cmd_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign do_push = push && !full  && !flush;
    assign do_pop  = pop  && !empty && !flush;
    assign rd_data = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop in the
    // block samples the pre-edge values, independent of statement order.
    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW + 1)'(1);
                2'b01:   level <= level - (AW + 1)'(1);
                default: ;
            endcase
        end
    end

    // NOTE: the storage array has no reset; emptiness is tracked by the
    // pointers and level, so stale entries are never observed.
    always_ff @(posedge iclk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/spi_cfg_master.sv
// -----------------------------------------------------------------------------
// spi_cfg_master
// Queues register writes and shifts each one out as a 16-bit SPI frame
// (address byte then data byte, each LSB first; slave samples on sclk rise).
//   iclk, rstn  : clock, asynchronous active-low reset
//   cmd_valid   : command offered; accepted when cmd_ready is high
//   cmd_addr    : target register address
//   cmd_data    : register write data
//   cmd_ready   : queue not full
//   flush       : empty the queue and abort the frame in flight
//   sclk_out    : serial clock, idles low
//   serial_out  : serial data, changes only while sclk_out is low
//   busy        : frame in progress / gap pending, or queue non-empty
//   done        : one-cycle pulse per completed frame
//   fifo_level  : number of queued commands
// -----------------------------------------------------------------------------
module spi_cfg_master
    import psec5_spi_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        iclk,
    input  logic                        rstn,
    input  logic                        cmd_valid,
    input  logic [7:0]                  cmd_addr,
    input  logic [7:0]                  cmd_data,
    output logic                        cmd_ready,
    input  logic                        flush,
    output logic                        sclk_out,
    output logic                        serial_out,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
    localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);

    spi_state_t             state;
    logic [3:0]             div_cnt;    // cycles spent in the current phase
    logic [3:0]             bit_cnt;    // index of the bit on the wire
    logic [FRAME_BITS-1:0]  shreg;
    spi_cmd_t               head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;

    // Flush wins over a pop so an aborted queue is never partly consumed.
    assign pop       = (state == IDLE) && !fifo_empty && !flush;
    assign cmd_ready = !fifo_full;
    assign busy      = (state != IDLE) || !fifo_empty;

    spi_cmd_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .iclk    (iclk),
        .rstn    (rstn),
        .flush   (flush),
        .push    (cmd_valid),
        .pop     (pop),
        .wr_data ({cmd_data, cmd_addr}),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            sclk_out   <= 1'b0;
            serial_out <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                // Abort: drop to GAP with the line quiet and no done pulse.
                state      <= GAP;
                div_cnt    <= '0;
                bit_cnt    <= '0;
                sclk_out   <= 1'b0;
                serial_out <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!fifo_empty) begin
                            shreg      <= head;
                            serial_out <= head.addr[0];
                            bit_cnt    <= '0;
                            div_cnt    <= '0;
                            state      <= SHIFT_LO;
                        end
                    end
                    SHIFT_LO: begin
                        if (div_cnt == DIV_LAST) begin
                            div_cnt  <= '0;
                            sclk_out <= 1'b1;
                            state    <= SHIFT_HI;
                        end else begin
                            div_cnt <= div_cnt + 4'd1;
                        end
                    end
                    SHIFT_HI: begin
                        if (div_cnt == DIV_LAST) begin
                            div_cnt  <= '0;
                            sclk_out <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                serial_out <= 1'b0;
                                done       <= 1'b1;
                                state      <= GAP;
                            end else begin
                                // Next bit is presented on the falling edge so
                                // it is stable for the following rise.
                                bit_cnt    <= bit_cnt + 4'd1;
                                shreg      <= shreg >> 1;
                                serial_out <= shreg[1];
                                state      <= SHIFT_LO;
                            end
                        end else begin
                            div_cnt <= div_cnt + 4'd1;
                        end
                    end
                    GAP: begin
                        if (div_cnt == GAP_LAST) begin
                            div_cnt <= '0;
                            state   <= IDLE;
                        end else begin
                            div_cnt <= div_cnt + 4'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
